// File: rtl/arb_mux.sv
// Registered N-channel valid/ready multiplexer. The source channel comes from an
// external select or from round-robin arbitration. A counter tracks accepted beats.
module arb_mux #(
    parameter int  N     = 4,
    parameter int  WIDTH = 8,
    parameter int  MODE  = 0,
    parameter int  CNT_W = 16,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic [CNT_W-1:0]   beat_cnt
);

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] ch);
        if (int'(ch) == N - 1)
            return '0;
        return ch + 1'b1;
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [SEL_W-1:0] ch_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic [SEL_W-1:0] ptr_p1;

    logic             load;
    logic             grant;
    logic             xfer;
    logic [SEL_W-1:0] gnt_ch;

    // Stage 0: grant selection from the live request vector
    always_comb begin
        int cand;
        grant  = 1'b0;
        gnt_ch = '0;
        cand   = 0;
        if (MODE == 0) begin
            if (int'(sel) < N) begin
                grant  = in_valid[sel];
                gnt_ch = sel;
            end
        end else begin
            // Descending scan so the candidate closest to ptr is the last one written.
            for (int k = N - 1; k >= 0; k--) begin
                cand = int'(ptr_p1) + k;
                if (cand >= N)
                    cand = cand - N;
                if (in_valid[cand]) begin
                    grant  = 1'b1;
                    gnt_ch = SEL_W'(cand);
                end
            end
        end
    end

    assign load = ~vld_p1 | out_ready;
    assign xfer = load & grant & ~rst;

    always_comb begin
        in_ready = '0;
        if (xfer)
            in_ready[gnt_ch] = 1'b1;
    end

    // Stage 1: output register, beat counter and arbitration pointer
    always_ff @(posedge clock) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            cnt_p1  <= '0;
            ptr_p1  <= '0;
        end else if (load) begin
            if (xfer) begin
                vld_p1  <= 1'b1;
                data_p1 <= in_data[int'(gnt_ch)*WIDTH +: WIDTH];
                ch_p1   <= gnt_ch;
                cnt_p1  <= cnt_p1 + 1'b1;
                if (MODE == 1)
                    ptr_p1 <= wrap_inc(gnt_ch);
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
    assign beat_cnt  = cnt_p1;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: instance 0 uses external select with a 16-bit counter.
// Instance 1 uses round-robin with a 4-bit counter. Both are checked against a queue-free rule model.
module tb_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  tv[2];
    logic [31:0] td[2];
    logic [1:0]  tsel[2];
    logic        tor[2];

    logic [3:0]  ir0, ir1;
    logic        ov0, ov1;
    logic [7:0]  od0, od1;
    logic [1:0]  och0, och1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    logic [3:0]  ir[2];
    logic        ov[2];
    logic [7:0]  od[2];
    logic [1:0]  och[2];
    assign ir[0] = ir0;   assign ir[1] = ir1;
    assign ov[0] = ov0;   assign ov[1] = ov1;
    assign od[0] = od0;   assign od[1] = od1;
    assign och[0] = och0; assign och[1] = och1;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    arb_mux #(.N(4), .WIDTH(8), .MODE(0), .CNT_W(16)) u_sel (
        .clock(clk), .rst(rst), .in_valid(tv[0]), .in_ready(ir0), .in_data(td[0]),
        .sel(tsel[0]), .out_valid(ov0), .out_ready(tor[0]), .out_data(od0),
        .out_ch(och0), .beat_cnt(cnt0)
    );

    arb_mux #(.N(4), .WIDTH(8), .MODE(1), .CNT_W(4)) u_rr (
        .clock(clk), .rst(rst), .in_valid(tv[1]), .in_ready(ir1), .in_data(td[1]),
        .sel(tsel[1]), .out_valid(ov1), .out_ready(tor[1]), .out_data(od1),
        .out_ch(och1), .beat_cnt(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int i);
        return (i == 0) ? 32'(cnt0) : 32'(cnt1);
    endfunction

    // Behavioural model: instance index doubles as MODE, counters wrap at 2^16 and 2^4.
    int m_v[2], m_d[2], m_ch[2], m_cnt[2], m_ptr[2];
    int mg;

    function automatic int grant_of(input int i, input logic [3:0] v, input logic [1:0] s, input int ptr);
        if (i == 0)
            return v[s] ? int'(s) : -1;
        for (int k = 0; k < 4; k++)
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic int exp_ready(input int i);
        int g;
        if (rst || !(m_v[i] == 0 || tor[i])) return 0;
        g = grant_of(i, tv[i], tsel[i], m_ptr[i]);
        return (g < 0) ? 0 : (1 << g);
    endfunction

    initial for (int i = 0; i < 2; i++) begin
        m_v[i] = 0; m_d[i] = 0; m_ch[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_v[i] = 0; m_d[i] = 0; m_ch[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
            end else if (m_v[i] == 0 || tor[i]) begin
                mg = grant_of(i, tv[i], tsel[i], m_ptr[i]);
                if (mg >= 0) begin
                    m_v[i]   = 1;
                    m_d[i]   = int'(td[i][mg*8 +: 8]);
                    m_ch[i]  = mg;
                    m_cnt[i] = (m_cnt[i] + 1) % ((i == 0) ? 65536 : 16);
                    if (i == 1) m_ptr[i] = (mg + 1) % 4;
                end else begin
                    m_v[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model%0d out_valid", i), 32'(ov[i]),  m_v[i]);
                chk($sformatf("model%0d out_data", i),  32'(od[i]),  m_d[i]);
                chk($sformatf("model%0d out_ch", i),    32'(och[i]), m_ch[i]);
                chk($sformatf("model%0d beat_cnt", i),  cnt_of(i),   m_cnt[i]);
                chk($sformatf("model%0d in_ready", i),  32'(ir[i]),  exp_ready(i));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input int i, input logic ev, input logic [7:0] ed, input logic [1:0] ec, input int ecnt);
        chk($sformatf("lit%0d out_valid", i), 32'(ov[i]),  32'(ev));
        chk($sformatf("lit%0d out_data", i),  32'(od[i]),  32'(ed));
        chk($sformatf("lit%0d out_ch", i),    32'(och[i]), 32'(ec));
        chk($sformatf("lit%0d beat_cnt", i),  cnt_of(i),   ecnt);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tv[i] = 4'hF; td[i] = 32'h0; tsel[i] = 2'd0; tor[i] = 1'b1;
        end

        // Reset held two edges with every channel requesting
        for (int r = 0; r < 2; r++) begin
            step();
            chk_on = 1'b1;
            chk("rst ir0", 32'(ir0), 32'h0);
            chk("rst ir1", 32'(ir1), 32'h0);
            lit(0, 1'b0, 8'h00, 2'd0, 0);
            lit(1, 1'b0, 8'h00, 2'd0, 0);
        end

        // External select passthrough, then a select with no request
        rst = 1'b0;
        tv[1] = 4'h0;
        tsel[0] = 2'd2; tv[0] = 4'b0100; td[0] = 32'h00A5_0000;
        #1 chk("sel2 ir0", 32'(ir0), 32'b0100);
        step();
        lit(0, 1'b1, 8'hA5, 2'd2, 1);
        tsel[0] = 2'd3;
        #1 chk("sel3 ir0", 32'(ir0), 32'h0);
        step();
        lit(0, 1'b0, 8'hA5, 2'd2, 1);

        // Backpressure holds the 8'h11 beat for three cycles
        tsel[0] = 2'd1; tv[0] = 4'b0010; td[0] = 32'h0000_1122;
        step();
        lit(0, 1'b1, 8'h11, 2'd1, 2);
        tor[0] = 1'b0; tsel[0] = 2'd0; tv[0] = 4'b0001;
        for (int r = 0; r < 3; r++) begin
            #1 chk("bp ir0", 32'(ir0), 32'h0);
            step();
            lit(0, 1'b1, 8'h11, 2'd1, 2);
        end
        tor[0] = 1'b1;
        #1 chk("release ir0", 32'(ir0), 32'b0001);
        step();
        lit(0, 1'b1, 8'h22, 2'd0, 3);
        tv[0] = 4'h0;
        step();
        lit(0, 1'b0, 8'h22, 2'd0, 3);

        // Round-robin fairness with all channels, then channels 1 and 3 only
        td[1] = 32'h4342_4140; tv[1] = 4'hF; tor[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            lit(1, 1'b1, 8'(8'h40 + (k - 1) % 4), 2'((k - 1) % 4), k % 16);
        end
        tv[1] = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            lit(1, 1'b1, (k % 2) ? 8'h43 : 8'h41, (k % 2) ? 2'd3 : 2'd1, 9 + k);
        end

        // Counter wrap: 17 transfers from a fresh reset on the 4-bit counter
        rst = 1'b1;
        step();
        lit(0, 1'b0, 8'h00, 2'd0, 0);
        lit(1, 1'b0, 8'h00, 2'd0, 0);
        rst = 1'b0; tv[1] = 4'hF;
        for (int k = 1; k <= 17; k++) begin
            step();
            lit(1, 1'b1, 8'(8'h40 + (k - 1) % 4), 2'((k - 1) % 4), k % 16);
        end

        // Reset while a beat is held; pointer was 1 and must restart at 0
        tor[1] = 1'b0;
        step();
        lit(1, 1'b1, 8'h40, 2'd0, 1);
        rst = 1'b1;
        step();
        lit(1, 1'b0, 8'h00, 2'd0, 0);
        rst = 1'b0; tor[1] = 1'b1;
        step();
        lit(1, 1'b1, 8'h40, 2'd0, 1);
        step();
        lit(1, 1'b1, 8'h41, 2'd1, 2);

        tv[1] = 4'h0;
        step();
        lit(1, 1'b0, 8'h41, 2'd1, 2);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
